// File: rtl/uart_emitter.sv
// 8N1 UART transmitter: accepts one byte on a valid/ready handshake and
// serialises it with DIV = clk_freq_hz / baud_rate clock cycles per bit.
module uart_emitter #(
  parameter int unsigned clk_freq_hz = 12000000,
  parameter int unsigned baud_rate   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_uart_tx
);

  localparam int unsigned DIV   = clk_freq_hz / baud_rate;
  localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_emitter: clk_freq_hz / baud_rate must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       sh, sh_n;
  logic             tx, tx_n;
  logic             wrap;

  assign wrap      = (cnt == CNT_LAST);
  assign o_ready   = (state == IDLE);
  assign o_uart_tx = tx;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      tx    <= tx_n;
    end
  end

  // The line flop is loaded with the value of the bit that begins on this edge,
  // so the start bit appears on the acceptance edge itself.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    tx_n    = tx;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        tx_n  = 1'b1;
        if (i_valid) begin
          state_n = START;
          sh_n    = i_data;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (wrap) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          tx_n    = sh[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (wrap) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
            sh_n  = {1'b0, sh[7:1]};
            tx_n  = sh[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (wrap) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_emitter.sv
// Directed bench for uart_emitter: one instance at default rates (DIV=104)
// and one at clk_freq_hz=8, baud_rate=1 (DIV=8).
module tb_uart_emitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_d, valid_d, ready_d, tx_d;
  logic [7:0] data_d;
  logic       rstn_8, valid_8, ready_8, tx_8;
  logic [7:0] data_8;

  uart_emitter u_def (
    .i_clk    (clk),
    .i_rstn   (rstn_d),
    .i_data   (data_d),
    .i_valid  (valid_d),
    .o_ready  (ready_d),
    .o_uart_tx(tx_d)
  );

  uart_emitter #(.clk_freq_hz(8), .baud_rate(1)) u_d8 (
    .i_clk    (clk),
    .i_rstn   (rstn_8),
    .i_data   (data_8),
    .i_valid  (valid_8),
    .o_ready  (ready_8),
    .o_uart_tx(tx_8)
  );

  int   total  = 0;
  int   passes = 0;
  logic sel    = 1'b0;
  logic tx_m, ready_m;

  assign tx_m    = sel ? tx_8 : tx_d;
  assign ready_m = sel ? ready_8 : ready_d;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  // Checks cycles k0..k1-1 of a frame whose start bit was launched on the
  // edge just before cycle 0; leaves the bench at the negedge of cycle k1.
  task automatic span(input string name, input logic [7:0] d, input int div,
                      input int k0, input int k1);
    logic [9:0] fr;
    logic       exp_tx;
    fr = {1'b1, d, 1'b0};
    for (int k = k0; k < k1; k++) begin
      exp_tx = (k < 10 * div) ? fr[k / div] : 1'b1;
      chk($sformatf("%s tx k=%0d", name, k), tx_m, exp_tx);
      chk($sformatf("%s ready k=%0d", name, k), ready_m, (k >= 10 * div));
      @(negedge clk);
    end
  endtask

  initial begin
    rstn_d  = 1'b0; rstn_8  = 1'b0;
    valid_d = 1'b1; valid_8 = 1'b1;
    data_d  = 8'hFF; data_8 = 8'hFF;
    repeat (3) @(negedge clk);
    chk("reset tx def", tx_d, 1'b1);
    chk("reset ready def", ready_d, 1'b1);
    chk("reset tx d8", tx_8, 1'b1);
    chk("reset ready d8", ready_8, 1'b1);
    valid_d = 1'b0; valid_8 = 1'b0;
    rstn_d  = 1'b1; rstn_8  = 1'b1;
    @(negedge clk);
    chk("idle tx def", tx_d, 1'b1);
    chk("idle ready d8", ready_8, 1'b1);

    // Default rate, single 0x55 pulse
    sel = 1'b0; data_d = 8'h55; valid_d = 1'b1;
    @(negedge clk);
    valid_d = 1'b0;
    span("b55", 8'h55, 104, 0, 1050);

    // DIV=8, valid held high: 0xA3 then 0x0F back to back
    sel = 1'b1; data_8 = 8'hA3; valid_8 = 1'b1;
    @(negedge clk);
    data_8 = 8'h0F;
    span("a3", 8'hA3, 8, 0, 81);
    span("0f", 8'h0F, 8, 0, 1);
    valid_8 = 1'b0;
    span("0f", 8'h0F, 8, 1, 85);

    // Request during a frame is dropped
    data_8 = 8'h00; valid_8 = 1'b1;
    @(negedge clk);
    valid_8 = 1'b0;
    span("drop", 8'h00, 8, 0, 20);
    data_8 = 8'hFF; valid_8 = 1'b1;
    span("drop", 8'h00, 8, 20, 21);
    valid_8 = 1'b0;
    span("drop", 8'h00, 8, 21, 90);

    // Data changes after acceptance do not reach the line
    data_8 = 8'h3C; valid_8 = 1'b1;
    @(negedge clk);
    valid_8 = 1'b0;
    span("hold", 8'h3C, 8, 0, 1);
    data_8 = 8'hC3;
    span("hold", 8'h3C, 8, 1, 82);

    // Asynchronous abort at cycle 37 of a 0x00 frame
    data_8 = 8'h00; valid_8 = 1'b1;
    @(negedge clk);
    valid_8 = 1'b0;
    span("abort", 8'h00, 8, 0, 37);
    chk("abort pre tx", tx_8, 1'b0);
    chk("abort pre ready", ready_8, 1'b0);
    rstn_8 = 1'b0;
    #1;
    chk("abort async tx", tx_8, 1'b1);
    chk("abort async ready", ready_8, 1'b1);
    @(negedge clk);
    chk("abort held tx", tx_8, 1'b1);
    chk("abort held ready", ready_8, 1'b1);

    // Acceptance on the very first edge after reset release
    rstn_8 = 1'b1; data_8 = 8'h5A; valid_8 = 1'b1;
    @(negedge clk);
    valid_8 = 1'b0;
    span("post", 8'h5A, 8, 0, 85);

    chk("def still idle tx", tx_d, 1'b1);
    chk("def still idle ready", ready_d, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
